// File: rtl/demux_route_if.sv
// Handshake bundle around demux_route_ctrl: one flit input port and a
// shared-data output port with one valid/ready pair per destination.
interface demux_route_if #(
  parameter int nbits    = 32,
  parameter int noutputs = 4
);
  localparam int selw = $clog2(noutputs);

  logic                recv_val;
  logic                recv_rdy;
  logic [nbits-1:0]    recv_msg;
  logic [noutputs-1:0] send_val;
  logic [noutputs-1:0] send_rdy;
  logic [nbits-1:0]    send_msg;
  logic [selw-1:0]     cur_sel;

  modport master (
    output recv_val, recv_msg, send_rdy,
    input  recv_rdy, send_val, send_msg, cur_sel
  );

  modport slave (
    input  recv_val, recv_msg, send_rdy,
    output recv_rdy, send_val, send_msg, cur_sel
  );
endinterface

// File: rtl/demux_route_ctrl.sv
// Packet demultiplexer: the header flit's top bits pick an output port, which
// stays latched for the whole packet; a one-entry buffer feeds the outputs.
module demux_route_ctrl #(
  parameter int nbits    = 32,
  parameter int noutputs = 4,
  parameter int pkt_len  = 4
) (
  input  logic          clk,
  input  logic          reset,
  demux_route_if.slave  io
);
  localparam int selw = $clog2(noutputs);
  localparam bit single_flit = (pkt_len == 1);
  localparam logic [8:0] pkt_len_w = 9'(pkt_len);
  localparam logic [noutputs-1:0] one_hot_base = {{(noutputs-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [7:0]          cnt_r;
  logic [7:0]          cnt_nxt_s;
  logic [8:0]          cnt_inc_s;
  logic [nbits-1:0]    buf_msg_r;
  logic [nbits-1:0]    buf_msg_nxt_s;
  logic                buf_full_r;
  logic                buf_full_nxt_s;
  logic [selw-1:0]     buf_sel_r;
  logic [selw-1:0]     buf_sel_nxt_s;
  logic [selw-1:0]     dest_s;
  logic                flush_s;
  logic                out_fire_s;
  logic                in_fire_s;
  logic                recv_rdy_s;

  assign dest_s     = io.recv_msg[nbits-1 -: selw];
  assign cnt_inc_s  = {1'b0, cnt_r} + 9'd1;
  assign out_fire_s = buf_full_r & io.send_rdy[buf_sel_r];
  // A header for a new route must wait until the last flit of the old route has left.
  assign flush_s    = (state_r == HDR) & buf_full_r & (buf_sel_r != dest_s);
  assign recv_rdy_s = (~buf_full_r | out_fire_s) & ~flush_s & ~reset;
  assign in_fire_s  = io.recv_val & recv_rdy_s;

  assign io.recv_rdy = recv_rdy_s;
  assign io.send_msg = buf_msg_r;
  assign io.cur_sel  = buf_sel_r;
  assign io.send_val = buf_full_r ? (one_hot_base << buf_sel_r) : {noutputs{1'b0}};

  // Next-state logic for the packet FSM, flit counter and output buffer.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    buf_msg_nxt_s  = buf_msg_r;
    buf_full_nxt_s = buf_full_r;
    buf_sel_nxt_s  = buf_sel_r;
    if (in_fire_s) begin
      buf_msg_nxt_s  = io.recv_msg;
      buf_full_nxt_s = 1'b1;
      case (state_r)
        HDR: begin
          buf_sel_nxt_s = dest_s;
          cnt_nxt_s     = 8'd1;
          if (single_flit) begin
            state_nxt_s = HDR;
          end else begin
            state_nxt_s = BODY;
          end
        end
        BODY: begin
          if (cnt_inc_s == pkt_len_w) begin
            state_nxt_s = HDR;
            cnt_nxt_s   = 8'd0;
          end else begin
            state_nxt_s = BODY;
            cnt_nxt_s   = cnt_inc_s[7:0];
          end
        end
        default: begin
          state_nxt_s = HDR;
          cnt_nxt_s   = 8'd0;
        end
      endcase
    end else if (out_fire_s) begin
      buf_full_nxt_s = 1'b0;
    end else begin
      buf_full_nxt_s = buf_full_r;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= HDR;
      cnt_r      <= 8'd0;
      buf_msg_r  <= {nbits{1'b0}};
      buf_full_r <= 1'b0;
      buf_sel_r  <= {selw{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      buf_msg_r  <= buf_msg_nxt_s;
      buf_full_r <= buf_full_nxt_s;
      buf_sel_r  <= buf_sel_nxt_s;
    end
  end
endmodule

// File: tb/tb_demux_route_ctrl.sv
// Self-checking bench for demux_route_ctrl: a pkt_len=4 instance for directed
// scenarios and a pkt_len=1 instance for a randomized reference-model run.
module tb_demux_route_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] msg;
  } exp_t;

  exp_t sbq[$];
  exp_t sbq1[$];
  int   m_cnt = 0;
  logic [1:0] m_sel = 2'd0;

  demux_route_if #(.nbits(32), .noutputs(4)) bus ();
  demux_route_if #(.nbits(32), .noutputs(4)) bus1 ();

  demux_route_ctrl #(.nbits(32), .noutputs(4), .pkt_len(4)) dut (
    .clk(clk), .reset(reset), .io(bus)
  );
  demux_route_ctrl #(.nbits(32), .noutputs(4), .pkt_len(1)) dut1 (
    .clk(clk), .reset(reset), .io(bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Bench routing model for 4-flit packets: header top bits pick the output.
  task automatic model_accept(input logic [31:0] m);
    exp_t e;
    if (m_cnt == 0) m_sel = m[31:30];
    e.sel = m_sel;
    e.msg = m;
    sbq.push_back(e);
    m_cnt = (m_cnt + 1) % 4;
  endtask

  // Drive one cycle on the main instance and report the handshakes about to fire.
  task automatic cycle_io(input logic rst, input logic v, input logic [31:0] m,
                          input logic [3:0] rdy, output logic in_f, output logic out_f);
    @(negedge clk);
    reset        = rst;
    bus.recv_val = v;
    bus.recv_msg = m;
    bus.send_rdy = rdy;
    #1;
    in_f  = v & bus.recv_rdy;
    out_f = ((bus.send_val & rdy) != 4'b0000);
  endtask

  task automatic test_reset();
    logic in_f, out_f;
    for (int i = 0; i < 3; i++) begin
      cycle_io(1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF, in_f, out_f);
      checks++;
      if (bus.recv_rdy !== 1'b0) begin
        errors++; $display("FAIL reset_recv_rdy: got %b want 0", bus.recv_rdy);
      end
      checks++;
      if (bus.send_val !== 4'b0000 || bus.send_msg !== 32'h0 || bus.cur_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs: got val %b msg %h sel %0d want 0 0 0",
                 bus.send_val, bus.send_msg, bus.cur_sel);
      end
    end
    sbq.delete(); m_cnt = 0;
    cycle_io(1'b0, 1'b0, 32'h0, 4'hF, in_f, out_f);
    checks++;
    if (bus.send_val !== 4'b0000 || bus.send_msg !== 32'h0 || bus.cur_sel !== 2'd0 ||
        bus1.send_val !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset_outputs: got val %b msg %h sel %0d val1 %b want all 0",
               bus.send_val, bus.send_msg, bus.cur_sel, bus1.send_val);
    end
  endtask

  task automatic test_single_packet();
    logic [31:0] fl [4] = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004};
    logic in_f, out_f;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      cycle_io(1'b0, (i < 4), fl[i % 4], 4'hF, in_f, out_f);
      if (i < 4) begin
        checks++;
        if (in_f !== 1'b1) begin
          errors++; $display("FAIL single_accept[%0d]: got recv_rdy %b want 1", i, bus.recv_rdy);
        end
      end
      checks++;
      if (i >= 1 && i <= 4) begin
        if (bus.send_val !== 4'b1000 || bus.cur_sel !== 2'd3) begin
          errors++; $display("FAIL single_val[%0d]: got val %b sel %0d want 1000 3", i, bus.send_val, bus.cur_sel);
        end
      end else if (bus.send_val !== 4'b0000) begin
        errors++; $display("FAIL single_idle[%0d]: got val %b want 0000", i, bus.send_val);
      end
      if (out_f) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL single_extra: got val %b want no output", bus.send_val);
        end else begin
          e = sbq.pop_front();
          if (bus.send_msg !== e.msg || bus.cur_sel !== e.sel) begin
            errors++; $display("FAIL single_out: got %h/%0d want %h/%0d", bus.send_msg, bus.cur_sel, e.msg, e.sel);
          end
        end
      end
      if (in_f) model_accept(fl[i % 4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] fl [8] = '{32'h4000_0001, 32'h4000_0002, 32'h4000_0003, 32'h4000_0004,
                            32'h8000_0000, 32'h8000_0001, 32'h8000_0002, 32'h8000_0003};
    logic in_f, out_f, v;
    int idx = 0, stalls = 0, delivered = 0;
    exp_t e;
    for (int cyc = 0; cyc < 30 && delivered < 8; cyc++) begin
      v = (idx < 8);
      cycle_io(1'b0, v, fl[idx % 8], 4'hF, in_f, out_f);
      if (v && !in_f) stalls++;
      if (out_f) begin
        checks++;
        delivered++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got val %b want no output", bus.send_val);
        end else begin
          e = sbq.pop_front();
          if (bus.send_msg !== e.msg || bus.cur_sel !== e.sel || bus.send_val !== (4'b0001 << e.sel)) begin
            errors++;
            $display("FAIL b2b_out: got msg %h sel %0d val %b want msg %h sel %0d",
                     bus.send_msg, bus.cur_sel, bus.send_val, e.msg, e.sel);
          end
        end
      end
      if (in_f) begin
        model_accept(fl[idx % 8]);
        idx++;
      end
    end
    checks++;
    if (delivered != 8) begin
      errors++; $display("FAIL b2b_delivered: got %0d want 8", delivered);
    end
    checks++;
    if (stalls != 1) begin
      errors++; $display("FAIL b2b_stalls: got %0d want 1", stalls);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] fl [4] = '{32'h4000_0011, 32'h4000_0022, 32'h4000_0033, 32'h4000_0044};
    logic in_f, out_f, v;
    logic [3:0] rdy;
    int idx = 0, delivered = 0;
    exp_t e;
    for (int cyc = 0; cyc < 40 && delivered < 4; cyc++) begin
      v = (idx < 4);
      rdy = 4'hF;
      if (cyc >= 2 && cyc < 7) begin
        rdy[1] = 1'b0;
        rdy[0] = 1'((cyc % 2));
      end
      cycle_io(1'b0, v, fl[idx % 4], rdy, in_f, out_f);
      if (cyc >= 2 && cyc < 7) begin
        checks++;
        if (bus.recv_rdy !== 1'b0) begin
          errors++; $display("FAIL bp_recv_rdy[%0d]: got %b want 0", cyc, bus.recv_rdy);
        end
        checks++;
        if (sbq.size() != 1 || bus.send_val !== 4'b0010 || bus.send_msg !== fl[1]) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got val %b msg %h want 0010 %h", cyc, bus.send_val, bus.send_msg, fl[1]);
        end
      end
      if (out_f) begin
        checks++;
        delivered++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL bp_extra: got val %b want no output", bus.send_val);
        end else begin
          e = sbq.pop_front();
          if (bus.send_msg !== e.msg || bus.cur_sel !== e.sel || bus.send_val !== (4'b0001 << e.sel)) begin
            errors++; $display("FAIL bp_out: got %h/%0d want %h/%0d", bus.send_msg, bus.cur_sel, e.msg, e.sel);
          end
        end
      end
      if (in_f) begin
        model_accept(fl[idx % 4]);
        idx++;
      end
    end
    checks++;
    if (delivered != 4) begin
      errors++; $display("FAIL bp_delivered: got %0d want 4", delivered);
    end
  endtask

  task automatic test_throughput();
    logic in_f, out_f;
    int accepted = 0, delivered = 0;
    exp_t e;
    for (int cyc = 0; cyc < 13; cyc++) begin
      cycle_io(1'b0, (cyc < 12), 32'h0000_1000 + 32'(cyc), 4'hF, in_f, out_f);
      if (out_f) begin
        checks++;
        if (cyc >= 1) delivered++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL tput_extra: got val %b want no output", bus.send_val);
        end else begin
          e = sbq.pop_front();
          if (bus.send_msg !== e.msg || bus.send_val !== 4'b0001) begin
            errors++; $display("FAIL tput_out: got %h/%b want %h/0001", bus.send_msg, bus.send_val, e.msg);
          end
        end
      end
      if (in_f) begin
        accepted++;
        model_accept(32'h0000_1000 + 32'(cyc));
      end
    end
    checks++;
    if (accepted != 12) begin
      errors++; $display("FAIL tput_accepted: got %0d want 12", accepted);
    end
    checks++;
    if (delivered != 12) begin
      errors++; $display("FAIL tput_delivered: got %0d want 12", delivered);
    end
  endtask

  task automatic test_midpacket_reset();
    logic in_f, out_f;
    exp_t e;
    cycle_io(1'b0, 1'b1, 32'hC000_0005, 4'hF, in_f, out_f);
    checks++;
    if (in_f !== 1'b1) begin
      errors++; $display("FAIL mid_hdr_accept: got %b want 1", bus.recv_rdy);
    end
    if (in_f) model_accept(32'hC000_0005);
    cycle_io(1'b0, 1'b1, 32'hC000_0006, 4'hF, in_f, out_f);
    checks++;
    if (!out_f || sbq.size() == 0) begin
      errors++; $display("FAIL mid_hdr_out: got val %b want 1000", bus.send_val);
    end else begin
      e = sbq.pop_front();
      if (bus.send_msg !== e.msg) begin
        errors++; $display("FAIL mid_hdr_msg: got %h want %h", bus.send_msg, e.msg);
      end
    end
    cycle_io(1'b1, 1'b0, 32'h0, 4'h0, in_f, out_f);
    checks++;
    if (bus.recv_rdy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_rdy: got %b want 0", bus.recv_rdy);
    end
    sbq.delete(); m_cnt = 0;
    cycle_io(1'b0, 1'b1, 32'h4000_0000, 4'hF, in_f, out_f);
    checks++;
    if (bus.send_val !== 4'b0000 || bus.send_msg !== 32'h0 || bus.cur_sel !== 2'd0) begin
      errors++;
      $display("FAIL mid_after_reset: got val %b msg %h sel %0d want 0 0 0", bus.send_val, bus.send_msg, bus.cur_sel);
    end
    checks++;
    if (in_f !== 1'b1) begin
      errors++; $display("FAIL mid_new_accept: got %b want 1", bus.recv_rdy);
    end
    if (in_f) model_accept(32'h4000_0000);
    cycle_io(1'b0, 1'b0, 32'h0, 4'hF, in_f, out_f);
    checks++;
    if (bus.send_val !== 4'b0010 || bus.cur_sel !== 2'd1 || bus.send_msg !== 32'h4000_0000) begin
      errors++;
      $display("FAIL mid_new_route: got val %b sel %0d msg %h want 0010 1 40000000", bus.send_val, bus.cur_sel, bus.send_msg);
    end
    if (out_f && sbq.size() != 0) e = sbq.pop_front();
  endtask

  task automatic test_random_pkt1();
    logic v, in_f, out_f, exp_rdy;
    logic [31:0] m;
    logic [3:0] rdy, exp_val;
    exp_t e;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v   = ($urandom_range(0, 3) != 0);
      m   = $urandom();
      rdy = 4'($urandom_range(0, 15));
      if (cyc >= 9990) begin
        v = 1'b0; rdy = 4'hF;
      end
      @(negedge clk);
      bus1.recv_val = v;
      bus1.recv_msg = m;
      bus1.send_rdy = rdy;
      #1;
      if (sbq1.size() == 0) begin
        exp_rdy = 1'b1;
        exp_val = 4'b0000;
      end else begin
        exp_rdy = rdy[sbq1[0].sel] && (sbq1[0].sel == m[31:30]);
        exp_val = 4'b0001 << sbq1[0].sel;
      end
      checks++;
      if (bus1.recv_rdy !== exp_rdy) begin
        errors++; $display("FAIL rnd_recv_rdy[%0d]: got %b want %b", cyc, bus1.recv_rdy, exp_rdy);
      end
      checks++;
      if (bus1.send_val !== exp_val || (sbq1.size() != 0 && bus1.send_msg !== sbq1[0].msg)) begin
        errors++; $display("FAIL rnd_send[%0d]: got val %b msg %h want val %b", cyc, bus1.send_val, bus1.send_msg, exp_val);
      end
      in_f  = v & exp_rdy;
      out_f = ((exp_val & rdy) != 4'b0000);
      if (out_f) e = sbq1.pop_front();
      if (in_f) begin
        e.sel = m[31:30];
        e.msg = m;
        sbq1.push_back(e);
      end
    end
    checks++;
    if (sbq1.size() != 0) begin
      errors++; $display("FAIL rnd_drain: got %0d flits left want 0", sbq1.size());
    end
  endtask

  initial begin
    bus.recv_val  = 1'b0;
    bus.recv_msg  = 32'h0;
    bus.send_rdy  = 4'h0;
    bus1.recv_val = 1'b0;
    bus1.recv_msg = 32'h0;
    bus1.send_rdy = 4'h0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_backpressure();
    test_throughput();
    test_midpacket_reset();
    test_random_pkt1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_route_ctrl.md
DEMUX_ROUTE_CTRL -- requirements
Module: demux_route_ctrl

Interface
REQ-001 Parameter nbits, default 32, flit width in bits; SHALL satisfy nbits > $clog2(noutputs).
REQ-002 Parameter noutputs, default 4, number of output ports; SHALL be a power of two, at least 2.
REQ-003 Parameter pkt_len, default 4, flits per packet including the header flit; SHALL be in the range 1..255.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port recv_val, input, 1 bit: an input flit is valid.
REQ-007 Port recv_rdy, output, 1 bit: the block accepts the input flit this cycle.
REQ-008 Port recv_msg, input, nbits bits: input flit.
REQ-009 Port send_val, output, noutputs bits: per-output valid; at most one bit is set at a time.
REQ-010 Port send_rdy, input, noutputs bits: per-output ready.
REQ-011 Port send_msg, output, nbits bits: flit presented to all outputs.
REQ-012 Port cur_sel, output, $clog2(noutputs) bits: the currently latched route; this is the demux select.

Function
REQ-013 Destination SHALL be header flit bits [nbits-1 : nbits-$clog2(noutputs)].
REQ-014 Transfer rules:
  - Input fire = recv_val & recv_rdy.
  - Output fire = send_val[cur_sel] & send_rdy[cur_sel].
REQ-015 The block SHALL hold a one-entry output buffer made of buf_msg, buf_full and buf_sel.
  - send_msg = buf_msg.
  - send_val = one-hot(buf_sel) when buf_full, else all zero.
  - cur_sel = buf_sel.
REQ-016 recv_rdy SHALL be (!buf_full | output fire) & !flush; the combinational path from send_rdy to recv_rdy is permitted.
REQ-017 Latency: a flit accepted in cycle N SHALL appear on send_msg with send_val asserted in cycle N+1.
REQ-018 FSM states:
  - HDR: the next flit is a header.
  - BODY: the next flit belongs to the current packet.
REQ-019 Flit counter cnt, 8 bits, counts flits accepted in the current packet.
REQ-020 On input fire in HDR:
  - buf_sel SHALL load the destination from the header.
  - cnt SHALL become 1.
  - The FSM SHALL go to BODY if pkt_len > 1, else stay in HDR.
REQ-021 On input fire in BODY:
  - buf_sel SHALL be unchanged.
  - cnt SHALL increment.
  - If cnt+1 == pkt_len, the FSM SHALL return to HDR and clear cnt.
REQ-022 flush is an internal signal, high while in HDR with buf_full and the buffered flit's route differing from the incoming header's destination.
  - While flush is high, recv_rdy SHALL be 0 so the previous packet's last flit leaves before buf_sel changes.
  - A new header to the same destination SHALL NOT stall.
REQ-023 Simultaneous input fire and output fire SHALL replace the buffer contents, leave buf_full at 1, and lose no flit.
REQ-024 Output fire without input fire SHALL clear buf_full.
REQ-025 Flits SHALL leave on a single output in acceptance order; flits of different packets SHALL never interleave.
REQ-026 send_msg SHALL be stable while send_val is asserted and not yet fired.
REQ-027 When send_rdy[cur_sel] = 0 with the buffer full, recv_rdy SHALL be 0; send_rdy bits for non-selected outputs SHALL be ignored.

Reset
REQ-028 While reset is high, at the next rising edge the block SHALL set:
  - FSM = HDR
  - cnt = 0
  - buf_full = 0
  - buf_sel = 0
  - buf_msg = 0
REQ-029 During reset and in the cycle after it, send_val SHALL be 0, send_msg 0 and cur_sel 0; recv_rdy SHALL be 0 while reset is high.
REQ-030 Reset asserted mid-packet SHALL discard the buffered flit and the partial count; the first flit accepted after reset SHALL be treated as a header.

Verification
REQ-031 Single packet, nbits=32, noutputs=4, pkt_len=4, all send_rdy=1: header 0xC0000001, then 3 body flits -> send_val=4'b1000 for 4 consecutive cycles starting 1 cycle after the header; cur_sel=3.
REQ-032 Back-to-back packets to outputs 1 then 2: header 0x80000000 follows the last flit of the first packet -> exactly one stall cycle on recv_rdy, send_val goes 4'b0010 then 4'b0100, and no flit is dropped.
REQ-033 Backpressure: send_rdy[1]=0 for 5 cycles mid-packet -> send_msg is held, recv_rdy=0, then 4 flits are delivered in order; toggling send_rdy[0] has no effect.
REQ-034 Throughput: 3 packets to output 0 with constant valid/ready -> 12 flits in 12 cycles with no bubbles.
REQ-035 Reset after the 2nd flit of a packet -> send_val=0; the next flit (0x40000000) routes to output 1 as a header.
REQ-036 pkt_len=1 build: every flit is routed by its own top bits; random val/rdy scoreboard against a reference demux model over 10k cycles -> no mismatch.
